nzcv_flag_tracker: RTL and testbench

Holds the architectural NZCV status register and tracks in-flight flag-setting instructions between issue from ID and flag commit. Drives the 4-bit status vector consumed by the ID-stage condition checker, either forwarding the youngest in-flight flags or stalling ID until they commit. Sits directly upstream of the condition checker and alongside the hazard unit.

---
 rtl/nzcv_flag_tracker.sv | 119 +++++++++++
 tb/tb_nzcv_flag_tracker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nzcv_flag_tracker.sv
// nzcv_flag_tracker: architectural NZCV register plus a shift-register of
// in-flight flag setters between ID issue and flag commit. Presents the
// status vector to the ID-stage condition checker, either forwarding the
// youngest in-flight flags (FWD_EN=1) or requesting an ID stall (FWD_EN=0).
//
// Ports:
//   clk         clock, all state updates on rising edge
//   rst_n       synchronous active-low reset (overrides freeze)
//   freeze      hold all state this cycle
//   flush       kill the instruction in ID (suppresses this cycle's issue)
//   id_issue    instruction leaves ID this cycle
//   id_s_bit    issuing instruction updates flags
//   id_cond     cond field of the instruction in ID
//   alu_flags   {N,Z,C,V} of the instruction in slot 0 (EXE), combinational
//   status_out  {N,Z,C,V} to the condition checker (combinational)
//   arch_flags  committed architectural flags (registered)
//   flag_stall  ID must not issue this cycle (combinational)
//   pending     number of valid slots (combinational)
module nzcv_flag_tracker #(
    parameter int unsigned FLAG_LAT = 2,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       freeze,
    input  logic       flush,
    input  logic       id_issue,
    input  logic       id_s_bit,
    input  logic [3:0] id_cond,
    input  logic [3:0] alu_flags,
    output logic [3:0] status_out,
    output logic [3:0] arch_flags,
    output logic       flag_stall,
    output logic [2:0] pending
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned PEND_W = 3;

    logic [FLAG_LAT-1:0]             v;
    logic [FLAG_LAT-1:0][FLAG_W-1:0] slot_flags;
    logic [FLAG_W-1:0]               arch;
    logic                            needs_flags;

    // Slot 0 flags come live from the ALU; older slots use captured copies.
    assign slot_flags[0] = alu_flags;

    generate
        if (FLAG_LAT > 1) begin : g_cap
            logic [FLAG_W-1:0] f [1:FLAG_LAT-1];

            // Captured flag pipeline for slots 1..FLAG_LAT-1.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 1; i < int'(FLAG_LAT); i++) begin
                        f[i] <= '0;
                    end
                end else if (!freeze) begin
                    f[1] <= alu_flags;
                    for (int i = 2; i < int'(FLAG_LAT); i++) begin
                        f[i] <= f[i-1];
                    end
                end
            end

            for (genvar g = 1; g < int'(FLAG_LAT); g++) begin : g_slot
                assign slot_flags[g] = f[g];
            end
        end
    endgenerate

    // Slot valid shift register; flush only kills the issuing instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
        end else if (!freeze) begin
            v[0] <= id_issue & id_s_bit & ~flush;
            for (int i = 1; i < int'(FLAG_LAT); i++) begin
                v[i] <= v[i-1];
            end
        end
    end

    // Commit from the last slot into the architectural register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arch <= '0;
        end else if (!freeze && v[FLAG_LAT-1]) begin
            arch <= slot_flags[FLAG_LAT-1];
        end
    end

    assign arch_flags = arch;

    // AL (1110) and NV (1111) do not read the flags.
    assign needs_flags = (id_cond[3:1] != 3'b111);

    // Scan oldest to youngest so the youngest valid slot wins.
    always_comb begin
        status_out = arch;
        if (FWD_EN) begin
            for (int i = int'(FLAG_LAT) - 1; i >= 0; i--) begin
                if (v[i]) begin
                    status_out = slot_flags[i];
                end
            end
        end
    end

    assign flag_stall = ~FWD_EN & needs_flags & (|v);

    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(FLAG_LAT); i++) begin
            pending = pending + PEND_W'(v[i]);
        end
    end

endmodule

// File: tb/tb_nzcv_flag_tracker.sv
// Directed bench: two trackers (forwarding and stalling, FLAG_LAT=2) share
// the same stimulus; expected values are hand-derived per cycle.
module tb_nzcv_flag_tracker;

    logic       clk = 1'b0;
    logic       rst_n, freeze, flush, id_issue, id_s_bit;
    logic [3:0] id_cond, alu_flags;
    logic [3:0] f_status, f_arch, s_status, s_arch;
    logic       f_stall, s_stall;
    logic [2:0] f_pend, s_pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nzcv_flag_tracker #(.FLAG_LAT(2), .FWD_EN(1'b1)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_issue(id_issue), .id_s_bit(id_s_bit), .id_cond(id_cond),
        .alu_flags(alu_flags), .status_out(f_status), .arch_flags(f_arch),
        .flag_stall(f_stall), .pending(f_pend)
    );

    nzcv_flag_tracker #(.FLAG_LAT(2), .FWD_EN(1'b0)) dut_stl (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_issue(id_issue), .id_s_bit(id_s_bit), .id_cond(id_cond),
        .alu_flags(alu_flags), .status_out(s_status), .arch_flags(s_arch),
        .flag_stall(s_stall), .pending(s_pend)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic iss, input logic [3:0] alu);
        id_issue  = iss;
        id_s_bit  = iss;
        alu_flags = alu;
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;
        id_issue = 1'b1; id_s_bit = 1'b1; id_cond = 4'b0000; alu_flags = 4'b1111;

        // Reset held for three cycles with active stimulus.
        repeat (3) tick();
        settle();
        check("rst_status", 8'(f_status), 8'h0);
        check("rst_arch",   8'(f_arch),   8'h0);
        check("rst_pend",   8'(f_pend),   8'h0);
        check("rst_stall",  8'(s_stall),  8'h0);
        check("rst_sarch",  8'(s_arch),   8'h0);
        rst_n = 1'b1; drive(1'b0, 4'b0000);
        tick();

        // Commit latency / stall mode: issue setter, EXE produces 0100.
        drive(1'b1, 4'b0000);
        tick();
        drive(1'b0, 4'b0100); settle();
        check("lat_t1_status", 8'(f_status), 8'h4);
        check("lat_t1_pend",   8'(f_pend),   8'h1);
        check("lat_t1_stall",  8'(s_stall),  8'h1);
        check("lat_t1_sstat",  8'(s_status), 8'h0);
        check("lat_t1_fstall", 8'(f_stall),  8'h0);
        tick();
        drive(1'b0, 4'b0000); settle();
        check("lat_t2_status", 8'(f_status), 8'h4);
        check("lat_t2_pend",   8'(f_pend),   8'h1);
        check("lat_t2_arch",   8'(f_arch),   8'h0);
        check("lat_t2_stall",  8'(s_stall),  8'h1);
        tick(); settle();
        check("lat_t3_arch",   8'(f_arch),   8'h4);
        check("lat_t3_pend",   8'(f_pend),   8'h0);
        check("lat_t3_status", 8'(f_status), 8'h4);
        check("lat_t3_stall",  8'(s_stall),  8'h0);
        check("lat_t3_sstat",  8'(s_status), 8'h4);

        // Forward priority: A (1000) then B (0010) back to back.
        drive(1'b1, 4'b0000);
        tick();
        drive(1'b1, 4'b1000); settle();
        check("fp_t1_status", 8'(f_status), 8'h8);
        tick();
        drive(1'b0, 4'b0010); id_cond = 4'b1110; settle();
        check("fp_t2_status", 8'(f_status), 8'h2);
        check("fp_t2_pend",   8'(f_pend),   8'h2);
        check("fp_t2_al",     8'(s_stall),  8'h0);
        tick();
        drive(1'b0, 4'b0000); id_cond = 4'b1111; settle();
        check("fp_t3_arch",   8'(f_arch),   8'h8);
        check("fp_t3_status", 8'(f_status), 8'h2);
        check("fp_t3_pend",   8'(f_pend),   8'h1);
        check("fp_t3_nv",     8'(s_stall),  8'h0);
        id_cond = 4'b0000; settle();
        check("fp_t3_stall",  8'(s_stall),  8'h1);
        tick(); settle();
        check("fp_t4_arch",   8'(f_arch),   8'h2);
        check("fp_t4_pend",   8'(f_pend),   8'h0);

        // Flush suppresses the issue.
        drive(1'b1, 4'b1111); flush = 1'b1;
        tick();
        drive(1'b0, 4'b1111); flush = 1'b0; settle();
        check("fl_pend", 8'(f_pend), 8'h0);
        tick(); settle();
        check("fl_arch", 8'(f_arch), 8'h2);

        // Freeze with one setter in slot 0; issue during freeze ignored.
        drive(1'b1, 4'b0000);
        tick();
        drive(1'b0, 4'b0001); freeze = 1'b1; settle();
        check("fz_t1_pend",   8'(f_pend),   8'h1);
        tick();
        id_issue = 1'b1; id_s_bit = 1'b1; settle();
        check("fz_t2_pend",   8'(f_pend),   8'h1);
        check("fz_t2_arch",   8'(f_arch),   8'h2);
        check("fz_t2_status", 8'(f_status), 8'h1);
        tick();
        drive(1'b0, 4'b0001); settle();
        check("fz_t3_pend",   8'(f_pend),   8'h1);
        check("fz_t3_stall",  8'(s_stall),  8'h1);
        tick();
        freeze = 1'b0; settle();
        check("fz_t4_pend",   8'(f_pend),   8'h1);
        tick();
        drive(1'b0, 4'b0000); settle();
        check("fz_t5_pend",   8'(f_pend),   8'h1);
        check("fz_t5_arch",   8'(f_arch),   8'h2);
        check("fz_t5_status", 8'(f_status), 8'h1);
        tick(); settle();
        check("fz_t6_arch",   8'(f_arch),   8'h1);
        check("fz_t6_pend",   8'(f_pend),   8'h0);

        // Simultaneous issue and commit keeps pending constant.
        drive(1'b1, 4'b0000);
        tick();
        drive(1'b0, 4'b0110);
        tick();
        drive(1'b1, 4'b0000); settle();
        check("sc_t2_pend", 8'(f_pend), 8'h1);
        tick();
        drive(1'b0, 4'b1010); settle();
        check("sc_t3_pend", 8'(f_pend), 8'h1);
        check("sc_t3_arch", 8'(f_arch), 8'h6);
        tick();
        drive(1'b0, 4'b0000);
        tick(); settle();
        check("sc_t5_arch", 8'(f_arch), 8'ha);

        // Reset mid-operation: neither in-flight setter commits.
        drive(1'b1, 4'b0000);
        tick();
        drive(1'b1, 4'b1100);
        tick();
        drive(1'b0, 4'b0011); settle();
        check("rm_pend2", 8'(f_pend), 8'h2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; drive(1'b0, 4'b0000); settle();
        check("rm_t3_pend",  8'(f_pend), 8'h0);
        check("rm_t3_arch",  8'(f_arch), 8'h0);
        tick();
        tick(); settle();
        check("rm_t5_arch",   8'(f_arch),   8'h0);
        check("rm_t5_status", 8'(f_status), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
